divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: signed/unsigned integer and unsigned fixed-point (Q1.WIDTH-1)
// modes, one quotient bit per cycle, valid/ready handshakes on both sides.
module divider_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             frac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] pr_hi, pr_lo, dsr;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg;

    // Operand decode and special-case detection at accept time
    logic             sgn, zero_div, sgn_ovf, frac_ovf, special;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] init_pr;

    always_comb begin
        sgn      = is_signed & ~frac;
        zero_div = (divisor == '0);
        sgn_ovf  = sgn && (dividend == MIN_NEG) && (divisor == '1);
        frac_ovf = frac && ({1'b0, dividend} >= {divisor, 1'b0});
        special  = zero_div | sgn_ovf | frac_ovf;
        a_mag    = (sgn && dividend[WIDTH-1]) ? WIDTH'(~dividend + WIDTH'(1)) : dividend;
        b_mag    = (sgn && divisor[WIDTH-1])  ? WIDTH'(~divisor + WIDTH'(1))  : divisor;
        init_pr  = frac ? ({{WIDTH{1'b0}}, dividend} << (WIDTH-1)) : {{WIDTH{1'b0}}, a_mag};
    end

    // One restoring shift-subtract step and the sign fix-up of its result
    logic [WIDTH:0]   trial;
    logic             take, last;
    logic [WIDTH-1:0] hi_nx, lo_nx, q_fin, r_fin;

    always_comb begin
        trial = {pr_hi, pr_lo[WIDTH-1]};
        take  = (trial >= {1'b0, dsr});
        hi_nx = take ? WIDTH'(trial - {1'b0, dsr}) : trial[WIDTH-1:0];
        lo_nx = {pr_lo[WIDTH-2:0], take};
        last  = (cnt == CW'(WIDTH-1));
        q_fin = q_neg ? WIDTH'(~lo_nx + WIDTH'(1)) : lo_nx;
        r_fin = r_neg ? WIDTH'(~hi_nx + WIDTH'(1)) : hi_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = special ? DONE : CALC;
            CALC:    if (last)     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Handshake flags, datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            pr_hi       <= '0;
            pr_lo       <= '0;
            dsr         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (!flush) begin
                if (state == IDLE && in_valid) begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (sgn_ovf) begin
                        quotient  <= MIN_NEG;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end else if (frac_ovf) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        overflow  <= 1'b1;
                    end else begin
                        pr_hi <= init_pr[2*WIDTH-1:WIDTH];
                        pr_lo <= init_pr[WIDTH-1:0];
                        dsr   <= b_mag;
                        q_neg <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg <= sgn && dividend[WIDTH-1];
                        cnt   <= '0;
                    end
                end else if (state == CALC) begin
                    pr_hi <= hi_nx;
                    pr_lo <= lo_nx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
            end
        end
    end

endmodule
